// File: rtl/host_req_splitter_pkg.sv
// ---------------------------------------------------------------------------
// host_req_splitter_pkg
// Purpose : shared types and helpers for the host request splitter.
//           - req_t        : host request descriptor (vaddr, len, routing meta, last)
//           - VADDR_BITS   : virtual address width (addresses wrap modulo 2^VADDR_BITS)
//           - LEN_BITS     : byte-length width
//           - split_state_e: splitter FSM states
//           - req_chunk_len: size of the next chunk for a given remainder/address
// Ports   : none (package)
// Config  : HOST_REQ_SPLIT_PAGE_EN is resolved in host_req_splitter; the helper
//           takes page_bits==0 to mean "no page limit".
// ---------------------------------------------------------------------------
package host_req_splitter_pkg;

    localparam int VADDR_BITS = 48;
    localparam int LEN_BITS   = 28;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } split_state_e;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic [5:0]            pid;
        logic [3:0]            dest;
        logic [1:0]            strm;
        logic                  ctl;
        logic                  last;
    } req_t;

    // Smallest of: remaining bytes, 2^xfer_bits, and (when page_bits != 0)
    // the bytes left before the next 2^page_bits boundary. Computed at
    // VADDR_BITS width so the page room (up to 2^page_bits) never truncates.
    function automatic logic [LEN_BITS-1:0] req_chunk_len(
        input logic [LEN_BITS-1:0]   rem,
        input logic [VADDR_BITS-1:0] vaddr,
        input int unsigned           xfer_bits,
        input int unsigned           page_bits
    );
        logic [VADDR_BITS-1:0] lim;
        logic [VADDR_BITS-1:0] mask;
        logic [VADDR_BITS-1:0] room;
        lim  = VADDR_BITS'(1) << xfer_bits;
        mask = '0;
        room = '0;
        if (page_bits != 0) begin
            mask = (VADDR_BITS'(1) << page_bits) - VADDR_BITS'(1);
            room = (mask - (vaddr & mask)) + VADDR_BITS'(1);
            if (room < lim) begin
                lim = room;
            end
        end
        if (VADDR_BITS'(rem) < lim) begin
            return rem;
        end
        return LEN_BITS'(lim);
    endfunction

endpackage

// File: rtl/host_req_splitter_if.sv
// ---------------------------------------------------------------------------
// host_req_splitter_if
// Purpose : valid/ready/data handshake carrying one req_t per beat.
// Signals : valid (source->sink), ready (sink->source), data (req_t, source->sink)
// Modports: m - source side (drives valid/data, samples ready)
//           s - sink side   (samples valid/data, drives ready)
// ---------------------------------------------------------------------------
interface host_req_splitter_if;
    import host_req_splitter_pkg::*;

    logic valid;
    logic ready;
    req_t data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);

endinterface

// File: rtl/host_req_splitter.sv
// ---------------------------------------------------------------------------
// host_req_splitter
// Purpose : accepts one req_t descriptor per s_req handshake and emits it on
//           m_req as a sequence of chunks, each at most 2^XFER_BITS bytes.
//           One chunk per cycle; a new descriptor is accepted in the same
//           cycle the final chunk of the previous one is taken, so
//           back-to-back descriptors flow without a bubble.
// Ports   : aclk    - clock
//           aresetn - asynchronous assert, synchronous release, active low
//           s_req   - incoming descriptors (sink side)
//           m_req   - outgoing chunks (source side)
//           busy    - high while a descriptor is being split
// Params  : XFER_BITS - log2 of the max chunk size in bytes
//           PAGE_BITS - log2 of the page size (page limit build only)
// Config  : `define HOST_REQ_SPLIT_PAGE_EN to also stop every chunk at the
//           next 2^PAGE_BITS address boundary.
// ---------------------------------------------------------------------------
module host_req_splitter
    import host_req_splitter_pkg::*;
#(
    parameter int unsigned XFER_BITS = 12,
    parameter int unsigned PAGE_BITS = 21
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    host_req_splitter_if.s        s_req,
    host_req_splitter_if.m        m_req,
    output logic                  busy
);

`ifdef HOST_REQ_SPLIT_PAGE_EN
    localparam int unsigned EFF_PAGE_BITS = PAGE_BITS;
`else
    // Zero disables the page limit inside req_chunk_len.
    localparam int unsigned EFF_PAGE_BITS = 0;
`endif

    split_state_e          r_state;
    split_state_e          w_state_next;
    req_t                  r_desc;
    logic [VADDR_BITS-1:0] r_cur_vaddr;
    logic [LEN_BITS-1:0]   r_rem;

    logic [LEN_BITS-1:0]   w_chunk;
    logic                  w_final;
    logic                  w_s_ready;
    logic                  w_s_hs;
    logic                  w_m_hs;
    req_t                  w_out;

    assign w_chunk = req_chunk_len(r_rem, r_cur_vaddr, XFER_BITS, EFF_PAGE_BITS);
    // len==0 gives chunk==0 and therefore final on the first beat.
    assign w_final = (r_rem <= w_chunk);
    assign w_m_hs  = (r_state == ST_SPLIT) && m_req.ready;

    // Ready while idle, or while the final chunk is being taken this cycle so
    // the next descriptor loads without a gap. Held low during reset.
    assign w_s_ready = aresetn &&
                       ((r_state == ST_IDLE) ||
                        ((r_state == ST_SPLIT) && w_final && m_req.ready));
    assign w_s_hs    = s_req.valid && w_s_ready;
    assign s_req.ready = w_s_ready;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_s_hs) begin
                    w_state_next = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                if (w_m_hs && w_final && !w_s_hs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Descriptor / progress registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_desc      <= '0;
            r_cur_vaddr <= '0;
            r_rem       <= '0;
        end else if (w_s_hs) begin
            r_desc      <= s_req.data;
            r_cur_vaddr <= s_req.data.vaddr;
            r_rem       <= s_req.data.len;
        end else if (w_m_hs && !w_final) begin
            // Address arithmetic wraps modulo 2^VADDR_BITS by construction.
            r_cur_vaddr <= r_cur_vaddr + VADDR_BITS'(w_chunk);
            r_rem       <= r_rem - w_chunk;
        end
    end

    // Output logic: everything is derived from registers, so the chunk stays
    // stable while stalled.
    always_comb begin
        w_out       = r_desc;
        w_out.vaddr = r_cur_vaddr;
        w_out.len   = w_chunk;
        w_out.last  = r_desc.last & w_final;
        m_req.valid = (r_state == ST_SPLIT);
        m_req.data  = w_out;
        busy        = (r_state == ST_SPLIT);
    end

endmodule

// File: tb/tb_host_req_splitter.sv
module tb_host_req_splitter;
    import host_req_splitter_pkg::*;

    localparam longint unsigned VMASK = (64'd1 << VADDR_BITS) - 64'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    host_req_splitter_if s_if ();
    host_req_splitter_if m_if ();

    host_req_splitter #(.XFER_BITS(12), .PAGE_BITS(21)) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .s_req   (s_if),
        .m_req   (m_if),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    req_t beats[$];
    int   beat_cyc[$];
    int   s_hs_cyc[$];
    req_t exp_q[$];

    bit   ready_manual = 1'b1;
    int   ready_pct    = 100;
    req_t prev_data;
    bit   prev_stall = 1'b0;

    typedef struct {
        req_t            d;
        int              exp_n;
        int              exp_first_len;
        int              exp_final_len;
        logic [47:0]     exp_final_vaddr;
    } vec_t;

    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    // Random ready generator, active only when the test hands control over.
    always begin
        @(posedge clk);
        #2;
        if (!ready_manual) m_if.ready = ($urandom_range(0, 99) < ready_pct);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Monitor: at the negedge, valid&ready means a handshake at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_if.valid || m_if.data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%h, required valid=1 data=%h",
                             m_if.valid, m_if.data, prev_data);
                end
            end
            if (m_if.valid && m_if.ready) begin
                beats.push_back(m_if.data);
                beat_cyc.push_back(cyc);
            end
            if (s_if.valid && s_if.ready) s_hs_cyc.push_back(cyc);
            prev_stall = m_if.valid && !m_if.ready;
            prev_data  = m_if.data;
        end
    end

    function automatic req_t mk(input logic [47:0] va, input int len, input bit last, input int tag);
        req_t r;
        r       = '0;
        r.vaddr = va;
        r.len   = LEN_BITS'(len);
        r.last  = last;
        r.pid   = 6'(tag * 7 + 3);
        r.dest  = 4'(tag + 1);
        r.strm  = 2'(tag);
        r.ctl   = tag[0];
        return r;
    endfunction

    function automatic logic [12:0] meta(input req_t r);
        return {r.pid, r.dest, r.strm, r.ctl};
    endfunction

    // Reference: each chunk ends at the earliest of start+remaining,
    // start+4096 and (page build) the next 2 MiB boundary.
    task automatic model_split(input req_t d);
        longint unsigned cur, rem, stop, c;
        req_t e;
        cur = 64'(d.vaddr);
        rem = 64'(d.len);
        do begin
            stop = cur + ((rem < 64'd4096) ? rem : 64'd4096);
`ifdef HOST_REQ_SPLIT_PAGE_EN
            begin
                longint unsigned pb;
                pb = ((cur >> 21) + 64'd1) << 21;
                if (pb < stop) stop = pb;
            end
`endif
            c       = stop - cur;
            e       = d;
            e.vaddr = VADDR_BITS'(cur);
            e.len   = LEN_BITS'(c);
            e.last  = d.last && (c == rem);
            exp_q.push_back(e);
            rem = rem - c;
            cur = stop & VMASK;
        end while (rem != 0);
    endtask

    // Called at posedge+1; presents each descriptor and holds valid until taken.
    task automatic send_seq(input req_t d[$]);
        bit ok;
        foreach (d[i]) begin
            s_if.data  = d[i];
            s_if.valid = 1'b1;
            ok = 1'b0;
            for (int n = 0; n < 2000; n++) begin
                @(negedge clk);
                if (s_if.ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("s_handshake_timeout", 64'd0, 64'd1);
            @(posedge clk);
            #1;
        end
        s_if.valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beats.delete();
        beat_cyc.delete();
        s_hs_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t q[$];
        int   sum;
        int   n;

        vecs[0] = '{mk(48'h1000, 10000, 1'b1, 0), 3, 4096, 1808, 48'h3000};
        vecs[1] = '{mk(48'h0, 0, 1'b1, 1), 1, 0, 0, 48'h0};
        vecs[2] = '{mk(48'h0, 4096, 1'b0, 2), 1, 4096, 4096, 48'h0};
        vecs[3] = '{mk(48'h10, 4097, 1'b1, 3), 2, 4096, 1, 48'h1010};
`ifdef HOST_REQ_SPLIT_PAGE_EN
        vecs[4] = '{mk(48'h1FF800, 4096, 1'b1, 4), 2, 2048, 2048, 48'h200000};
`else
        vecs[4] = '{mk(48'h1FF800, 4096, 1'b1, 4), 1, 4096, 4096, 48'h1FF800};
`endif
        vecs[5] = '{mk(48'hFFFF_FFFF_F000, 8192, 1'b1, 5), 2, 4096, 4096, 48'h0};

        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_s_ready", 64'(s_if.ready), 64'd0);
        chk("reset_m_valid", 64'(m_if.valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", 64'(s_if.ready), 64'd1);
        chk("idle_m_valid", 64'(m_if.valid), 64'd0);
        @(posedge clk);
        #1;
        m_if.ready = 1'b1;

        // Table-driven single descriptors, ready always high
        foreach (vecs[i]) begin
            clear_logs();
            q = '{vecs[i].d};
            send_seq(q);
            wait_idle();
            $display("vec %0d: vaddr=%h len=%0d last=%0b -> %0d chunks",
                     i, vecs[i].d.vaddr, vecs[i].d.len, vecs[i].d.last, beats.size());
            chk($sformatf("vec%0d_nchunks", i), 64'(beats.size()), 64'(vecs[i].exp_n));
            if (beats.size() > 0 && s_hs_cyc.size() > 0) begin
                chk($sformatf("vec%0d_first_len", i), 64'(beats[0].len), 64'(vecs[i].exp_first_len));
                chk($sformatf("vec%0d_first_vaddr", i), 64'(beats[0].vaddr), 64'(vecs[i].d.vaddr));
                chk($sformatf("vec%0d_first_last", i), 64'(beats[0].last),
                    (vecs[i].exp_n > 1) ? 64'd0 : 64'(vecs[i].d.last));
                chk($sformatf("vec%0d_final_len", i), 64'(beats[beats.size()-1].len), 64'(vecs[i].exp_final_len));
                chk($sformatf("vec%0d_final_vaddr", i), 64'(beats[beats.size()-1].vaddr), 64'(vecs[i].exp_final_vaddr));
                chk($sformatf("vec%0d_final_last", i), 64'(beats[beats.size()-1].last), 64'(vecs[i].d.last));
                chk($sformatf("vec%0d_meta", i), 64'(meta(beats[beats.size()-1])), 64'(meta(vecs[i].d)));
                chk($sformatf("vec%0d_latency", i), 64'(beat_cyc[0]), 64'(s_hs_cyc[0] + 1));
            end
        end

        // Back-to-back: two 4096-byte descriptors held valid
        clear_logs();
        q = '{mk(48'h4000, 4096, 1'b0, 6), mk(48'h9000, 4096, 1'b1, 7)};
        send_seq(q);
        wait_idle();
        $display("b2b: %0d chunks", beats.size());
        chk("b2b_nchunks", 64'(beats.size()), 64'd2);
        if (beats.size() == 2 && s_hs_cyc.size() == 2) begin
            chk("b2b_gap", 64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
            chk("b2b_accept_gap", 64'(s_hs_cyc[1] - s_hs_cyc[0]), 64'd1);
            chk("b2b_second_vaddr", 64'(beats[1].vaddr), 64'h9000);
            chk("b2b_second_last", 64'(beats[1].last), 64'd1);
        end

        // Backpressure: 30% ready on len=20000
        clear_logs();
        ready_pct    = 30;
        ready_manual = 1'b0;
        q = '{mk(48'h20_0000, 20000, 1'b1, 8)};
        send_seq(q);
        wait_idle();
        ready_manual = 1'b1;
        m_if.ready   = 1'b1;
        sum = 0;
        foreach (beats[i]) sum += int'(beats[i].len);
        $display("backpressure: %0d chunks, %0d bytes", beats.size(), sum);
        chk("bp_nchunks", 64'(beats.size()), 64'd5);
        chk("bp_byte_sum", 64'(sum), 64'd20000);

        // Reset in the middle of the second chunk
        clear_logs();
        m_if.ready = 1'b0;
        q = '{mk(48'h1000, 10000, 1'b1, 9)};
        send_seq(q);
        m_if.ready = 1'b1;
        @(posedge clk);
        #1 m_if.ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_second_vaddr", 64'(m_if.data.vaddr), 64'h2000);
        chk("rst_mid_taken", 64'(beats.size()), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_m_valid", 64'(m_if.valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_s_ready", 64'(s_if.ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_if.ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_after_beats", 64'(beats.size()), 64'd1);
        chk("rst_after_m_valid", 64'(m_if.valid), 64'd0);
        chk("rst_after_s_ready", 64'(s_if.ready), 64'd1);
        @(posedge clk);
        #1;

        // Randomized stream against the reference model
        clear_logs();
        q.delete();
        for (int i = 0; i < 30; i++) begin
            req_t d;
            logic [63:0] rv;
            rv = {$urandom(), $urandom()};
            d = mk(rv[47:0], 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0)
                d.vaddr = VADDR_BITS'((64'(rv[40:21]) << 21) - 64'($urandom_range(0, 5000)));
            case ($urandom_range(0, 3))
                0:       d.len = LEN_BITS'($urandom_range(0, 300));
                1:       d.len = 28'd0;
                default: d.len = LEN_BITS'($urandom_range(1, 20000));
            endcase
            q.push_back(d);
            model_split(d);
        end
        ready_pct    = 70;
        ready_manual = 1'b0;
        send_seq(q);
        wait_idle();
        ready_manual = 1'b1;
        m_if.ready   = 1'b1;
        $display("random: %0d descriptors, %0d chunks, %0d expected", q.size(), beats.size(), exp_q.size());
        chk("rand_nchunks", 64'(beats.size()), 64'(exp_q.size()));
        n = (beats.size() < exp_q.size()) ? beats.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rand%0d_vaddr", i), 64'(beats[i].vaddr), 64'(exp_q[i].vaddr));
            chk($sformatf("rand%0d_len", i), 64'(beats[i].len), 64'(exp_q[i].len));
            chk($sformatf("rand%0d_last", i), 64'(beats[i].last), 64'(exp_q[i].last));
            chk($sformatf("rand%0d_meta", i), 64'(meta(beats[i])), 64'(meta(exp_q[i])));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
